// File: rtl/framebuffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_pkg
// Description : Shared constants and types for the framebuffer read side.
//               Frame geometry (320x240 stored words), address/pixel widths,
//               default 640x480@60 timing, and the flag bundle carried down
//               the scanout pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package framebuffer_pkg;

  // Stored frame geometry and bus widths
  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_ADDR_W = 17;
  localparam int PIXEL_W   = 16;

  // Default 640x480@60 timing (800 x 525 total)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  // Counter width; 10 bits covers both 800 and 525 totals
  localparam int CNT_W = 10;

  // Timing flags produced alongside the counters, delayed one stage while
  // the framebuffer read is in flight. Sync flags here are active-high.
  typedef struct packed {
    logic active;
    logic even;
    logic h_sync;
    logic v_sync;
    logic frame_start;
  } scan_flags_t;

  // Map an active-high "in sync window" flag to the pin level.
  function automatic logic sync_level(input logic in_sync, input logic active_low);
    return in_sync ^ active_low;
  endfunction

endpackage
`default_nettype wire

// File: rtl/framebuffer_scanout_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Horizontal/vertical scan counters with sync windows, active
//               flag and line/frame strobes, all for the current counter
//               position (cycle t).
// Ports       : clk, rstN        - clock, async active-low reset
//               h_even, v_odd    - LSB views of hCount / vCount
//               active           - hCount < H_ACTIVE && vCount < V_ACTIVE
//               h_in_sync        - hCount inside horizontal sync window
//               v_in_sync        - vCount inside vertical sync window
//               line_end         - last active pixel of an active line
//               frame_end        - last counter position of the frame
//               frame_first      - counter position (0,0)
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
  import framebuffer_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK
) (
  input  logic clk,
  input  logic rstN,
  output logic h_even,
  output logic v_odd,
  output logic active,
  output logic h_in_sync,
  output logic v_in_sync,
  output logic line_end,
  output logic frame_end,
  output logic frame_first
);

  localparam int H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
  localparam int V_SYNC_START = V_ACTIVE + V_FRONT;

  logic [CNT_W-1:0] h_count_q, h_count_d;
  logic [CNT_W-1:0] v_count_q, v_count_d;
  logic             h_last, v_last;
  logic             h_vis, v_vis;

  always_comb begin
    h_last    = (h_count_q == CNT_W'(H_TOTAL - 1));
    v_last    = (v_count_q == CNT_W'(V_TOTAL - 1));
    h_count_d = h_last ? '0 : h_count_q + CNT_W'(1);
    v_count_d = v_count_q;
    if (h_last) begin
      v_count_d = v_last ? '0 : v_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      h_count_q <= '0;
      v_count_q <= '0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

  always_comb begin
    h_vis       = (h_count_q < CNT_W'(H_ACTIVE));
    v_vis       = (v_count_q < CNT_W'(V_ACTIVE));
    active      = h_vis & v_vis;
    h_even      = ~h_count_q[0];
    v_odd       = v_count_q[0];
    h_in_sync   = (h_count_q >= CNT_W'(H_SYNC_START)) &&
                  (h_count_q <  CNT_W'(H_SYNC_START + H_SYNC));
    v_in_sync   = (v_count_q >= CNT_W'(V_SYNC_START)) &&
                  (v_count_q <  CNT_W'(V_SYNC_START + V_SYNC));
    line_end    = (h_count_q == CNT_W'(H_ACTIVE - 1)) & v_vis;
    frame_end   = h_last & v_last;
    frame_first = (h_count_q == '0) && (v_count_q == '0);
  end

endmodule
`default_nettype wire

// File: rtl/framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_scanout
// Description : Framebuffer read side. Generates video timing, fetches one
//               RGB565 word per two pixels from framebuffer port B and shows
//               each word as a 2x2 block. Addresses are generated
//               incrementally from a per-line base (no multiplier).
// Ports       : clk, rstN     - pixel clock, async active-low reset
//               fbAddress     - framebuffer port B address
//               fbReadEnable  - read strobe (port B is read-only)
//               fbData        - read data, valid one clock after the read
//               pixel         - RGB565 output, 0 outside the active area
//               hsync, vsync  - sync outputs, polarity from SYNC_ACTIVE_LOW
//               de            - data enable (active area)
//               frameStart    - pulse with pixel (0,0) on the outputs
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_scanout
  import framebuffer_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rstN,
  output logic [FB_ADDR_W-1:0] fbAddress,
  output logic                 fbReadEnable,
  input  logic [PIXEL_W-1:0]   fbData,
  output logic [PIXEL_W-1:0]   pixel,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 frameStart
);

  // One stored word covers two output pixels, so a stored line is half the
  // visible width (320 words for the default timing).
  localparam logic [FB_ADDR_W-1:0] LINE_WORDS = FB_ADDR_W'(H_ACTIVE / 2);
  localparam logic                 SYNC_LOW   = (SYNC_ACTIVE_LOW != 0);

  logic h_even, v_odd, active, h_in_sync, v_in_sync;
  logic line_end, frame_end, frame_first;
  logic rd_en;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_timing (
    .clk         (clk),
    .rstN        (rstN),
    .h_even      (h_even),
    .v_odd       (v_odd),
    .active      (active),
    .h_in_sync   (h_in_sync),
    .v_in_sync   (v_in_sync),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .frame_first (frame_first)
  );

  // ---------------------------------------------------------------------------
  // Address generation (cycle t)
  // ---------------------------------------------------------------------------
  logic [FB_ADDR_W-1:0] line_base_q, line_base_d;
  logic [FB_ADDR_W-1:0] fb_address_q, fb_address_d;

  assign rd_en = active & h_even;

  // The read for (0,0) must be presented before the first edge after reset
  // release, so the strobe is combinational from the counters; gating with
  // rstN keeps it low while reset is held.
  assign fbReadEnable = rd_en & rstN;
  assign fbAddress    = fb_address_q;

  always_comb begin
    line_base_d  = line_base_q;
    fb_address_d = fb_address_q;
    if (rd_en) begin
      fb_address_d = fb_address_q + FB_ADDR_W'(1);
    end
    // Each stored line is shown twice: the base only advances after the odd
    // output line, and the address always rewinds to the (new) base.
    if (line_end) begin
      if (v_odd) begin
        line_base_d = line_base_q + LINE_WORDS;
      end
      fb_address_d = line_base_d;
    end
    if (frame_end) begin
      line_base_d  = '0;
      fb_address_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output pipeline: stage 1 (t+1) waits for fbData, stage 2 (t+2) registers
  // every output so sync, de and pixel stay aligned.
  // ---------------------------------------------------------------------------
  scan_flags_t          s1_q, s1_d;
  logic [PIXEL_W-1:0]   pixel_q, pixel_d;
  logic                 de_q, de_d;
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic                 frame_start_q, frame_start_d;

  always_comb begin
    s1_d.active      = active;
    s1_d.even        = h_even;
    s1_d.h_sync      = h_in_sync;
    s1_d.v_sync      = v_in_sync;
    s1_d.frame_start = frame_first;

    // Even pixel takes the fresh word, odd pixel repeats it.
    pixel_d = '0;
    if (s1_q.active) begin
      pixel_d = s1_q.even ? fbData : pixel_q;
    end
    de_d          = s1_q.active;
    hsync_d       = sync_level(s1_q.h_sync, SYNC_LOW);
    vsync_d       = sync_level(s1_q.v_sync, SYNC_LOW);
    frame_start_d = s1_q.frame_start;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      line_base_q   <= '0;
      fb_address_q  <= '0;
      s1_q          <= '0;
      pixel_q       <= '0;
      de_q          <= 1'b0;
      hsync_q       <= SYNC_LOW;
      vsync_q       <= SYNC_LOW;
      frame_start_q <= 1'b0;
    end else begin
      line_base_q   <= line_base_d;
      fb_address_q  <= fb_address_d;
      s1_q          <= s1_d;
      pixel_q       <= pixel_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel      = pixel_q;
  assign de         = de_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frameStart = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_scanout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_scanout
// Description : Bench for framebuffer_scanout using a reduced screen size so
//               whole frames fit in a short run. Instance A uses active-low
//               sync, instance B active-high sync. Expected outputs come from
//               a position-based model: output cycle k shows scan position
//               k-2, which maps to word (y/2)*(W/2)+x/2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_scanout;

  localparam int HA = 32, HF = 4, HS = 6, HB = 6;
  localparam int VA = 16, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int WORDS = (HA / 2) * (VA / 2);
  localparam int AW = $clog2(WORDS);

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [16:0] addr_a, addr_b;
  logic        rd_a, rd_b;
  logic [15:0] data_a, data_b, pix_a, pix_b;
  logic        hs_a, vs_a, de_a, fs_a;
  logic        hs_b, vs_b, de_b, fs_b;

  logic [15:0] mem [0:WORDS-1];
  int          read_cnt [0:WORDS-1];
  int          bad_addr, total_reads;
  int          de_total, hs_low, vs_low;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  framebuffer_scanout #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(1)
  ) dut_a (
    .clk(clk), .rstN(rstN), .fbAddress(addr_a), .fbReadEnable(rd_a),
    .fbData(data_a), .pixel(pix_a), .hsync(hs_a), .vsync(vs_a),
    .de(de_a), .frameStart(fs_a)
  );

  framebuffer_scanout #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(0)
  ) dut_b (
    .clk(clk), .rstN(rstN), .fbAddress(addr_b), .fbReadEnable(rd_b),
    .fbData(data_b), .pixel(pix_b), .hsync(hs_b), .vsync(vs_b),
    .de(de_b), .frameStart(fs_b)
  );

  // Behavioural framebuffer port B: synchronous read, one clock latency.
  always @(posedge clk) begin
    if (rd_a) data_a <= (int'(addr_a) < WORDS) ? mem[addr_a[AW-1:0]] : 16'hDEAD;
    if (rd_b) data_b <= (int'(addr_b) < WORDS) ? mem[addr_b[AW-1:0]] : 16'hDEAD;
  end

  // ---------------- reference model (scan position arithmetic) -------------
  function automatic bit m_read(input int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return (h < HA) && (v < VA) && (h % 2 == 0);
  endfunction

  function automatic int m_addr(input int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return (v / 2) * (HA / 2) + h / 2;
  endfunction

  task automatic fill_mem(input int mode);
    for (int a = 0; a < WORDS; a++) begin
      mem[a] = (mode == 0) ? a[15:0] : 16'($urandom);
      read_cnt[a] = 0;
    end
    bad_addr = 0;
    total_reads = 0;
  endtask

  // Walks ncyc cycles from reset release (k=0), comparing every output.
  task automatic test_scan(input int ncyc, input string tag);
    int  p, h, v;
    bit  e_de, e_fs, e_hs, e_vs;
    logic [15:0] e_pix;
    for (int k = 0; k < ncyc; k++) begin
      checks++;
      if (rd_a !== m_read(k)) begin
        errors++;
        $display("FAIL %s read_enable k=%0d got %b exp %b", tag, k, rd_a, m_read(k));
      end
      if (m_read(k)) begin
        checks++;
        if (addr_a !== 17'(m_addr(k))) begin
          errors++;
          $display("FAIL %s address k=%0d got %0d exp %0d", tag, k, addr_a, m_addr(k));
        end
      end
      if (rd_a === 1'b1) begin
        total_reads++;
        if (int'(addr_a) < WORDS) read_cnt[int'(addr_a)]++;
        else bad_addr++;
      end

      e_de = 0; e_fs = 0; e_hs = 0; e_vs = 0; e_pix = '0;
      if (k >= 2) begin
        p = k - 2;
        h = p % HT;
        v = (p / HT) % VT;
        e_de  = (h < HA) && (v < VA);
        e_pix = e_de ? mem[(v / 2) * (HA / 2) + h / 2] : 16'h0;
        e_hs  = (h >= HA + HF) && (h < HA + HF + HS);
        e_vs  = (v >= VA + VF) && (v < VA + VF + VS);
        e_fs  = (h == 0) && (v == 0);
      end
      checks += 8;
      if (de_a !== e_de) begin
        errors++; $display("FAIL %s de k=%0d got %b exp %b", tag, k, de_a, e_de);
      end
      if (pix_a !== e_pix) begin
        errors++; $display("FAIL %s pixel k=%0d got %h exp %h", tag, k, pix_a, e_pix);
      end
      if (fs_a !== e_fs) begin
        errors++; $display("FAIL %s frameStart k=%0d got %b exp %b", tag, k, fs_a, e_fs);
      end
      if (hs_a !== !e_hs) begin
        errors++; $display("FAIL %s hsync_low k=%0d got %b exp %b", tag, k, hs_a, !e_hs);
      end
      if (vs_a !== !e_vs) begin
        errors++; $display("FAIL %s vsync_low k=%0d got %b exp %b", tag, k, vs_a, !e_vs);
      end
      if (hs_b !== e_hs) begin
        errors++; $display("FAIL %s hsync_high k=%0d got %b exp %b", tag, k, hs_b, e_hs);
      end
      if (vs_b !== e_vs) begin
        errors++; $display("FAIL %s vsync_high k=%0d got %b exp %b", tag, k, vs_b, e_vs);
      end
      if (pix_b !== e_pix || de_b !== e_de || fs_b !== e_fs) begin
        errors++; $display("FAIL %s inst_b_video k=%0d got %h/%b/%b exp %h/%b/%b",
                           tag, k, pix_b, de_b, fs_b, e_pix, e_de, e_fs);
      end
      if (de_a === 1'b1) de_total++;
      if (hs_a === 1'b0) hs_low++;
      if (vs_a === 1'b0) vs_low++;
      @(negedge clk); #1;
    end
  endtask

  task automatic release_reset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    #1;
    de_total = 0; hs_low = 0; vs_low = 0;
  endtask

  task automatic check_inactive(input string tag);
    checks++;
    if (rd_a !== 1'b0 || addr_a !== 17'd0) begin
      errors++; $display("FAIL %s read_side got rd=%b addr=%0d exp rd=0 addr=0", tag, rd_a, addr_a);
    end
    checks++;
    if (pix_a !== 16'h0 || de_a !== 1'b0 || fs_a !== 1'b0) begin
      errors++; $display("FAIL %s video got pix=%h de=%b fs=%b exp 0/0/0", tag, pix_a, de_a, fs_a);
    end
    checks++;
    if (hs_a !== 1'b1 || vs_a !== 1'b1) begin
      errors++; $display("FAIL %s sync_low_idle got %b%b exp 11", tag, hs_a, vs_a);
    end
    checks++;
    if (hs_b !== 1'b0 || vs_b !== 1'b0 || de_b !== 1'b0 || rd_b !== 1'b0) begin
      errors++; $display("FAIL %s inst_b_idle got hs=%b vs=%b de=%b rd=%b exp 0000",
                         tag, hs_b, vs_b, de_b, rd_b);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_inactive("reset");
  endtask

  task automatic check_frame_totals(input int nframes, input int reads_per_word, input string tag);
    for (int a = 0; a < WORDS; a++) begin
      checks++;
      if (read_cnt[a] != reads_per_word) begin
        errors++; $display("FAIL %s read_count addr=%0d got %0d exp %0d", tag, a, read_cnt[a], reads_per_word);
      end
    end
    checks += 5;
    if (bad_addr != 0) begin
      errors++; $display("FAIL %s out_of_range_reads got %0d exp 0", tag, bad_addr);
    end
    if (total_reads != nframes * WORDS * 2) begin
      errors++; $display("FAIL %s total_reads got %0d exp %0d", tag, total_reads, nframes * WORDS * 2);
    end
    if (de_total != nframes * HA * VA) begin
      errors++; $display("FAIL %s de_cycles got %0d exp %0d", tag, de_total, nframes * HA * VA);
    end
    if (hs_low != nframes * VT * HS) begin
      errors++; $display("FAIL %s hsync_low_cycles got %0d exp %0d", tag, hs_low, nframes * VT * HS);
    end
    if (vs_low != nframes * VS * HT) begin
      errors++; $display("FAIL %s vsync_low_cycles got %0d exp %0d", tag, vs_low, nframes * VS * HT);
    end
  endtask

  task automatic test_frames(input int mode, input int nframes);
    fill_mem(mode);
    release_reset();
    test_scan(nframes * FRAME, mode == 0 ? "addr_pattern" : "random_data");
    check_frame_totals(nframes, 2 * nframes, mode == 0 ? "addr_pattern" : "random_data");
  endtask

  task automatic test_mid_reset();
    int line, x, target;
    fill_mem(1);
    release_reset();
    line   = $urandom_range(VA - 1, VA / 2);
    x      = $urandom_range(HA - 1, HA / 2);
    target = line * HT + x;
    test_scan(target, "pre_reset");
    // Reset lands between edges: outputs must drop without waiting for clk.
    rstN = 1'b0;
    #1;
    check_inactive("mid_reset");
    repeat (2) @(negedge clk);
    for (int a = 0; a < WORDS; a++) read_cnt[a] = 0;
    bad_addr = 0;
    total_reads = 0;
    rstN = 1'b1;
    #1;
    de_total = 0; hs_low = 0; vs_low = 0;
    test_scan(FRAME, "post_reset");
    check_frame_totals(1, 2, "post_reset");
  endtask

  initial begin
    test_reset();
    test_frames(0, 2);
    test_frames(1, 1);
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
